booth_datapath: RTL and testbench

//  Radix-2 Booth multiplier datapath, directly downstream of the Booth control FSM.

---
 rtl/booth_pkg.sv | 18 +
 rtl/booth_addsub.sv | 32 +++
 rtl/booth_datapath.sv | 123 ++++++++++++
 tb/tb_booth_datapath.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier datapath.
// Holds the Booth pair encodings and the iteration counter width helper.
package booth_pkg;

  // Booth pair {Q[0],Q_m1} encodings
  typedef enum logic [1:0] {
    BOOTH_NOP0 = 2'b00,
    BOOTH_ADD  = 2'b01,
    BOOTH_SUB  = 2'b10,
    BOOTH_NOP1 = 2'b11
  } booth_op_e;

  // Width needed for a counter that must hold the value n (0..n inclusive)
  function automatic int booth_cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/booth_addsub.sv
// Combinational N+1-bit Booth add/subtract step.
// Adds or subtracts the sign-extended multiplicand from the accumulator
// according to the Booth pair; passes the accumulator through otherwise.
// All arithmetic wraps modulo 2^(N+1).
module booth_addsub
  import booth_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N:0]   acc,
  input  logic [N-1:0] mcand,
  input  logic [1:0]   bits,
  output logic [N:0]   sum
);

  logic [N:0] mcand_sxt_s;

  assign mcand_sxt_s = {mcand[N-1], mcand};

  // Select A+M, A-M or A from the Booth pair
  always_comb begin
    sum = acc;
    case (bits)
      BOOTH_ADD:  sum = acc + mcand_sxt_s;
      BOOTH_SUB:  sum = acc - mcand_sxt_s;
      BOOTH_NOP0: sum = acc;
      BOOTH_NOP1: sum = acc;
      default:    sum = acc;
    endcase
  end

endmodule

// File: rtl/booth_datapath.sv
// Radix-2 Booth multiplier datapath driven by the Booth control FSM strobes.
// Holds M, the guarded accumulator A, Q, Q_m1 and the iteration counter.
// Optional feature macro: BOOTH_RESULT_REG_EN -- adds a result register that
// captures the product on completion and a result_valid output.
module booth_datapath
  import booth_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           add,
  input  logic           shift,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic [1:0]     bits,
  output logic           alarm,
  output logic [2*N-1:0] product
`ifdef BOOTH_RESULT_REG_EN
  ,
  output logic           result_valid
`endif
);

  localparam int CW = booth_cnt_width(N);

  logic [N-1:0]  m_r;
  logic [N:0]    a_r;
  logic [N-1:0]  q_r;
  logic          q_m1_r;
  logic [CW-1:0] cnt_r;
  logic          alarm_r;

  logic          busy_s;
  logic [1:0]    op_s;
  logic [N:0]    a_next_s;
  logic [N:0]    a_sh_s;
  logic [N-1:0]  q_sh_s;
  logic          q_m1_sh_s;
  logic          last_iter_s;

  assign busy_s      = (cnt_r != {CW{1'b0}});
  assign last_iter_s = busy_s && shift && (cnt_r == CW'(1));

  // Without an add strobe the shift operates on the unmodified accumulator
  always_comb begin
    op_s = BOOTH_NOP0;
    if (add) begin
      op_s = {q_r[0], q_m1_r};
    end else begin
      op_s = BOOTH_NOP0;
    end
  end

  booth_addsub #(.N(N)) u_addsub (
    .acc   (a_r),
    .mcand (m_r),
    .bits  (op_s),
    .sum   (a_next_s)
  );

  // Arithmetic right shift of {A',Q,Q_m1}; the guard bit supplies the sign
  assign {a_sh_s, q_sh_s, q_m1_sh_s} = {a_next_s[N], a_next_s, q_r};

  // Operand, accumulator and iteration registers; load has priority over add/shift
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_r     <= {N{1'b0}};
      a_r     <= {(N+1){1'b0}};
      q_r     <= {N{1'b0}};
      q_m1_r  <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      alarm_r <= 1'b0;
    end else if (load) begin
      m_r     <= multiplicand;
      a_r     <= {(N+1){1'b0}};
      q_r     <= multiplier;
      q_m1_r  <= 1'b0;
      cnt_r   <= CW'(N);
      alarm_r <= 1'b1;
    end else if (busy_s && shift) begin
      a_r     <= a_sh_s;
      q_r     <= q_sh_s;
      q_m1_r  <= q_m1_sh_s;
      cnt_r   <= cnt_r - CW'(1);
      alarm_r <= (cnt_r != CW'(1));
    end else if (busy_s && add) begin
      a_r     <= a_next_s;
    end else begin
      a_r     <= a_r;
    end
  end

  assign bits  = {q_r[0], q_m1_r};
  assign alarm = alarm_r;

`ifdef BOOTH_RESULT_REG_EN
  logic [2*N-1:0] res_r;
  logic           valid_r;

  // Capture the finished product on the final iteration; load clears valid only
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_r   <= {(2*N){1'b0}};
      valid_r <= 1'b0;
    end else if (load) begin
      valid_r <= 1'b0;
    end else if (last_iter_s) begin
      res_r   <= {a_sh_s[N-1:0], q_sh_s};
      valid_r <= 1'b1;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign product      = res_r;
  assign result_valid = valid_r;
`else
  assign product = {a_r[N-1:0], q_r};
`endif

endmodule

// File: tb/tb_booth_datapath.sv
// Directed self-checking bench for booth_datapath (N=8).
// Covers both the default build and the BOOTH_RESULT_REG_EN build.
module tb_booth_datapath;

  logic        clk;
  logic        rst;
  logic        load;
  logic        add;
  logic        shift;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic [1:0]  bits;
  logic        alarm;
  logic [15:0] product;
`ifdef BOOTH_RESULT_REG_EN
  logic        result_valid;
`endif

  int total;
  int bad;

  booth_datapath #(.N(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .add          (add),
    .shift        (shift),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .bits         (bits),
    .alarm        (alarm),
    .product      (product)
`ifdef BOOTH_RESULT_REG_EN
    ,
    .result_valid (result_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] mc, input logic [7:0] mp);
    multiplicand = mc;
    multiplier   = mp;
    load = 1'b1; add = 1'b0; shift = 1'b0;
    step();
    load = 1'b0;
  endtask

  task automatic run_iters(input int n);
    add = 1'b1; shift = 1'b1;
    repeat (n) step();
    add = 1'b0; shift = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; load = 1'b0; add = 1'b0; shift = 1'b0;
    multiplicand = 8'h00; multiplier = 8'h00;
    step(); step();
    total++; if (bits !== 2'b00) begin bad++; $display("FAIL reset_bits got=%b exp=%b", bits, 2'b00); end
    total++; if (alarm !== 1'b0) begin bad++; $display("FAIL reset_alarm got=%b exp=%b", alarm, 1'b0); end
    total++; if (product !== 16'h0000) begin bad++; $display("FAIL reset_product got=%h exp=%h", product, 16'h0000); end
`ifdef BOOTH_RESULT_REG_EN
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=%b", result_valid, 1'b0); end
`endif
    rst = 1'b1;
    step();
  endtask

  task automatic test_mult(input string name, input logic [7:0] mc, input logic [7:0] mp,
                           input logic [15:0] exp);
    do_load(mc, mp);
    total++; if (alarm !== 1'b1) begin bad++; $display("FAIL %s_alarm_after_load got=%b exp=%b", name, alarm, 1'b1); end
    total++; if (bits !== {mp[0], 1'b0}) begin bad++; $display("FAIL %s_bits_after_load got=%b exp=%b", name, bits, {mp[0], 1'b0}); end
    run_iters(7);
    total++; if (alarm !== 1'b1) begin bad++; $display("FAIL %s_alarm_iter7 got=%b exp=%b", name, alarm, 1'b1); end
    run_iters(1);
    total++; if (alarm !== 1'b0) begin bad++; $display("FAIL %s_alarm_iter8 got=%b exp=%b", name, alarm, 1'b0); end
    total++; if (product !== exp) begin bad++; $display("FAIL %s_product got=%h exp=%h", name, product, exp); end
`ifdef BOOTH_RESULT_REG_EN
    total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL %s_valid got=%b exp=%b", name, result_valid, 1'b1); end
`endif
  endtask

  task automatic test_extra_after_done();
    test_mult("x3x5", 8'h03, 8'h05, 16'h000F);
    run_iters(3);
    total++; if (product !== 16'h000F) begin bad++; $display("FAIL extra_product got=%h exp=%h", product, 16'h000F); end
    total++; if (alarm !== 1'b0) begin bad++; $display("FAIL extra_alarm got=%b exp=%b", alarm, 1'b0); end
  endtask

  task automatic test_load_priority();
    multiplicand = 8'h03; multiplier = 8'h05;
    load = 1'b1; add = 1'b1; shift = 1'b1;
    step();
    load = 1'b0; add = 1'b0; shift = 1'b0;
    total++; if (alarm !== 1'b1) begin bad++; $display("FAIL prio_alarm got=%b exp=%b", alarm, 1'b1); end
    total++; if (bits !== 2'b10) begin bad++; $display("FAIL prio_bits got=%b exp=%b", bits, 2'b10); end
`ifndef BOOTH_RESULT_REG_EN
    total++; if (product !== 16'h0005) begin bad++; $display("FAIL prio_product got=%h exp=%h", product, 16'h0005); end
`endif
    // A full count of 8 must still be needed
    run_iters(7);
    total++; if (alarm !== 1'b1) begin bad++; $display("FAIL prio_alarm_iter7 got=%b exp=%b", alarm, 1'b1); end
    run_iters(1);
    total++; if (alarm !== 1'b0) begin bad++; $display("FAIL prio_alarm_iter8 got=%b exp=%b", alarm, 1'b0); end
    total++; if (product !== 16'h000F) begin bad++; $display("FAIL prio_product_final got=%h exp=%h", product, 16'h000F); end
  endtask

  task automatic test_restart();
    do_load(8'h07, 8'h07);
    run_iters(3);
    total++; if (alarm !== 1'b1) begin bad++; $display("FAIL restart_alarm_mid got=%b exp=%b", alarm, 1'b1); end
    test_mult("restart_2xm1", 8'h02, 8'hFF, 16'hFFFE);
  endtask

  task automatic test_reset_mid();
    do_load(8'h03, 8'h05);
    run_iters(4);
    #2;
    rst = 1'b0;
    #1;
    total++; if (alarm !== 1'b0) begin bad++; $display("FAIL rstmid_alarm got=%b exp=%b", alarm, 1'b0); end
    total++; if (bits !== 2'b00) begin bad++; $display("FAIL rstmid_bits got=%b exp=%b", bits, 2'b00); end
    total++; if (product !== 16'h0000) begin bad++; $display("FAIL rstmid_product got=%h exp=%h", product, 16'h0000); end
`ifdef BOOTH_RESULT_REG_EN
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b exp=%b", result_valid, 1'b0); end
`endif
    step();
    rst = 1'b1;
    step();
  endtask

`ifdef BOOTH_RESULT_REG_EN
  task automatic test_result_reg();
    test_mult("rr_3x5", 8'h03, 8'h05, 16'h000F);
    do_load(8'h07, 8'h07);
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL rr_valid_after_load got=%b exp=%b", result_valid, 1'b0); end
    total++; if (product !== 16'h000F) begin bad++; $display("FAIL rr_hold_after_load got=%h exp=%h", product, 16'h000F); end
    run_iters(4);
    total++; if (product !== 16'h000F) begin bad++; $display("FAIL rr_hold_mid got=%h exp=%h", product, 16'h000F); end
    run_iters(4);
    total++; if (product !== 16'h0031) begin bad++; $display("FAIL rr_new_product got=%h exp=%h", product, 16'h0031); end
    total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL rr_valid_new got=%b exp=%b", result_valid, 1'b1); end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_mult("p3_5",      8'h03, 8'h05, 16'h000F);
    test_mult("m3_5",      8'hFD, 8'h05, 16'hFFF1);
    test_mult("p5_m3",     8'h05, 8'hFD, 16'hFFF1);
    test_mult("m128_m128", 8'h80, 8'h80, 16'h4000);
    test_mult("m128_127",  8'h80, 8'h7F, 16'hC080);
    test_extra_after_done();
    test_load_priority();
    test_restart();
    test_reset_mid();
`ifdef BOOTH_RESULT_REG_EN
    test_result_reg();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a stuck run
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
